// File: rtl/bc_imem_loader.sv
// ---------------------------------------------------------------------------
// bc_imem_loader
//
// Boot-time instruction memory loader. A byte stream carries a 4-byte word
// count N (LSB first), N 32-bit instruction words (each LSB first) and a
// trailing 8-bit XOR checksum over the payload bytes. Each assembled word is
// written to instruction memory at BASE_ADDR + k. The processor fetch stage
// is held while a load is in progress or has failed.
//
// Ports
//   i_clk             : clock, all state changes on the rising edge
//   i_rst             : synchronous active-high reset
//   i_start           : arm a load (honoured in IDLE or ERR only)
//   i_byte_valid      : stream byte offered
//   i_byte            : stream byte
//   o_byte_ready      : loader accepts i_byte this cycle (HDR, DATA, CHK)
//   o_mem_wen         : memory write enable (one cycle per word)
//   o_mem_wdata_valid : write data valid, identical to o_mem_wen
//   o_mem_waddr       : memory word address, held between writes
//   o_mem_wdata       : memory write word, held between writes
//   o_core_hold       : keep the fetch stage in reset (HDR, DATA, CHK, ERR)
//   o_done            : one-cycle pulse on a successful load
//   o_err             : sticky load error, cleared by i_start or i_rst
//   o_words_written   : words written by the current or last load
// ---------------------------------------------------------------------------
module bc_imem_loader #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned BASE_ADDR  = 0,
   parameter int unsigned MAX_WORDS  = 1024
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_start,
   input  logic                  i_byte_valid,
   input  logic [7:0]            i_byte,
   output logic                  o_byte_ready,
   output logic                  o_mem_wen,
   output logic                  o_mem_wdata_valid,
   output logic [ADDR_WIDTH-1:0] o_mem_waddr,
   output logic [DATA_WIDTH-1:0] o_mem_wdata,
   output logic                  o_core_hold,
   output logic                  o_done,
   output logic                  o_err,
   output logic [ADDR_WIDTH-1:0] o_words_written
);

   localparam logic [ADDR_WIDTH-1:0] BASE_A = ADDR_WIDTH'(BASE_ADDR);
   localparam logic [ADDR_WIDTH-1:0] ONE_A  = ADDR_WIDTH'(1);
   localparam logic [31:0]           MAX_N  = 32'(MAX_WORDS);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_HDR  = 3'd1,
      S_DATA = 3'd2,
      S_CHK  = 3'd3,
      S_DONE = 3'd4,
      S_ERR  = 3'd5
   } state_e;

   // States in which the stream is consumed.
   function automatic logic f_ready(input state_e s);
      return (s == S_HDR) || (s == S_DATA) || (s == S_CHK);
   endfunction

   // States in which the core must stay held.
   function automatic logic f_hold(input state_e s);
      return (s == S_HDR) || (s == S_DATA) || (s == S_CHK) || (s == S_ERR);
   endfunction

   state_e                  state_q, state_d;
   logic [1:0]              byte_cnt_q, byte_cnt_d;
   logic [31:0]             asm_q, asm_d;
   logic [31:0]             n_q, n_d;
   logic [31:0]             k_q, k_d;
   logic [7:0]              xor_q, xor_d;
   logic                    ready_q, ready_d;
   logic                    wen_q, wen_d;
   logic [ADDR_WIDTH-1:0]   waddr_q, waddr_d;
   logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
   logic                    hold_q, hold_d;
   logic                    done_q, done_d;
   logic                    err_q, err_d;
   logic [ADDR_WIDTH-1:0]   words_q, words_d;

   logic                    accept_s;
   logic [31:0]             asm_next_s;

   // Next-state, datapath and registered-output computation.
   always_comb begin
      state_d    = state_q;
      byte_cnt_d = byte_cnt_q;
      asm_d      = asm_q;
      n_d        = n_q;
      k_d        = k_q;
      xor_d      = xor_q;
      wen_d      = 1'b0;
      waddr_d    = waddr_q;
      wdata_d    = wdata_q;
      words_d    = words_q;

      // ready_q is a registered copy of f_ready(state_q), so it is the
      // handshake qualifier for the current state.
      accept_s   = i_byte_valid & ready_q;
      // Bytes arrive LSB first: shift right so byte 0 ends in bits [7:0].
      asm_next_s = {i_byte, asm_q[31:8]};

      case (state_q)
         S_IDLE, S_ERR: begin
            if (i_start) begin
               state_d    = S_HDR;
               byte_cnt_d = 2'd0;
               asm_d      = 32'd0;
               n_d        = 32'd0;
               k_d        = 32'd0;
               xor_d      = 8'd0;
               words_d    = {ADDR_WIDTH{1'b0}};
            end else begin
               state_d    = state_q;
            end
         end

         S_HDR: begin
            if (accept_s) begin
               asm_d      = asm_next_s;
               byte_cnt_d = byte_cnt_q + 2'd1;
               if (byte_cnt_q == 2'd3) begin
                  n_d = asm_next_s;
                  if (asm_next_s > MAX_N) begin
                     state_d = S_ERR;
                  end else if (asm_next_s == 32'd0) begin
                     state_d = S_CHK;
                  end else begin
                     state_d = S_DATA;
                  end
               end else begin
                  state_d = S_HDR;
               end
            end else begin
               state_d = S_HDR;
            end
         end

         S_DATA: begin
            if (accept_s) begin
               asm_d      = asm_next_s;
               xor_d      = xor_q ^ i_byte;
               byte_cnt_d = byte_cnt_q + 2'd1;
               if (byte_cnt_q == 2'd3) begin
                  // Registered write: appears the cycle after the 4th byte,
                  // while the stream keeps flowing.
                  wen_d   = 1'b1;
                  waddr_d = BASE_A + ADDR_WIDTH'(k_q);
                  wdata_d = DATA_WIDTH'(asm_next_s);
                  words_d = words_q + ONE_A;
                  k_d     = k_q + 32'd1;
                  if (k_q == (n_q - 32'd1)) begin
                     state_d = S_CHK;
                  end else begin
                     state_d = S_DATA;
                  end
               end else begin
                  state_d = S_DATA;
               end
            end else begin
               state_d = S_DATA;
            end
         end

         S_CHK: begin
            if (accept_s) begin
               if (i_byte == xor_q) begin
                  state_d = S_DONE;
               end else begin
                  state_d = S_ERR;
               end
            end else begin
               state_d = S_CHK;
            end
         end

         S_DONE: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Status outputs are registered decodes of the next state so that
      // they line up exactly with state_q in the following cycle.
      ready_d = f_ready(state_d);
      hold_d  = f_hold(state_d);
      done_d  = (state_d == S_DONE);
      err_d   = (state_d == S_ERR);
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q    <= S_IDLE;
         byte_cnt_q <= 2'd0;
         asm_q      <= 32'd0;
         n_q        <= 32'd0;
         k_q        <= 32'd0;
         xor_q      <= 8'd0;
         ready_q    <= 1'b0;
         wen_q      <= 1'b0;
         waddr_q    <= {ADDR_WIDTH{1'b0}};
         wdata_q    <= {DATA_WIDTH{1'b0}};
         hold_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         words_q    <= {ADDR_WIDTH{1'b0}};
      end else begin
         state_q    <= state_d;
         byte_cnt_q <= byte_cnt_d;
         asm_q      <= asm_d;
         n_q        <= n_d;
         k_q        <= k_d;
         xor_q      <= xor_d;
         ready_q    <= ready_d;
         wen_q      <= wen_d;
         waddr_q    <= waddr_d;
         wdata_q    <= wdata_d;
         hold_q     <= hold_d;
         done_q     <= done_d;
         err_q      <= err_d;
         words_q    <= words_d;
      end
   end

   assign o_byte_ready      = ready_q;
   assign o_mem_wen         = wen_q;
   assign o_mem_wdata_valid = wen_q;
   assign o_mem_waddr       = waddr_q;
   assign o_mem_wdata       = wdata_q;
   assign o_core_hold       = hold_q;
   assign o_done            = done_q;
   assign o_err             = err_q;
   assign o_words_written   = words_q;

endmodule

// File: tb/tb_bc_imem_loader.sv
// Self-checking bench for bc_imem_loader: directed and randomized loads
// compared against a stream-level reference model.
module tb_bc_imem_loader;

   localparam int unsigned DW   = 32;
   localparam int unsigned AW   = 32;
   localparam int unsigned BASE = 0;
   localparam int unsigned MAXW = 1024;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic          bvalid;
   logic [7:0]    bdata;
   logic          o_byte_ready;
   logic          o_mem_wen;
   logic          o_mem_wdata_valid;
   logic [AW-1:0] o_mem_waddr;
   logic [DW-1:0] o_mem_wdata;
   logic          o_core_hold;
   logic          o_done;
   logic          o_err;
   logic [AW-1:0] o_words_written;

   bc_imem_loader #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BASE_ADDR(BASE), .MAX_WORDS(MAXW)
   ) dut (
      .i_clk(clk), .i_rst(rst), .i_start(start), .i_byte_valid(bvalid),
      .i_byte(bdata), .o_byte_ready(o_byte_ready), .o_mem_wen(o_mem_wen),
      .o_mem_wdata_valid(o_mem_wdata_valid), .o_mem_waddr(o_mem_waddr),
      .o_mem_wdata(o_mem_wdata), .o_core_hold(o_core_hold), .o_done(o_done),
      .o_err(o_err), .o_words_written(o_words_written)
   );

   always #5 clk = ~clk;

   int            n_cmp  = 0;
   int            n_fail = 0;
   int            done_cnt = 0;
   logic          last_ready;
   logic [AW-1:0] cap_addr[$];
   logic [DW-1:0] cap_data[$];
   logic [7:0]    stream_q[$];
   logic [AW-1:0] exp_addr[$];
   logic [DW-1:0] exp_data[$];
   bit            exp_done;
   bit            exp_err;
   int            exp_consumed;
   int unsigned   exp_cnt;

   // Record what the DUT shows in this cycle (called at the negedge).
   task automatic sample();
      n_cmp++;
      if (o_mem_wen !== o_mem_wdata_valid) begin
         n_fail++;
         $display("FAIL wdata_valid: got %b, want %b (o_mem_wen)", o_mem_wdata_valid, o_mem_wen);
      end
      if (o_mem_wen === 1'b1) begin
         cap_addr.push_back(o_mem_waddr);
         cap_data.push_back(o_mem_wdata);
      end
      if (o_done === 1'b1) done_cnt++;
      last_ready = o_byte_ready;
   endtask

   task automatic tick();
      @(negedge clk);
      sample();
      @(posedge clk);
      #1;
   endtask

   // Reference model: parse the whole stream by the framing rules.
   function automatic void run_model();
      logic [31:0] n;
      logic [31:0] w;
      logic [7:0]  x;
      int          p;
      exp_addr.delete();
      exp_data.delete();
      exp_done = 1'b0;
      exp_err  = 1'b0;
      exp_cnt  = 0;
      n = {stream_q[3], stream_q[2], stream_q[1], stream_q[0]};
      if (n > MAXW) begin
         exp_err      = 1'b1;
         exp_consumed = 4;
      end else begin
         x = 8'd0;
         p = 4;
         for (int k = 0; k < int'(n); k++) begin
            w = {stream_q[p+3], stream_q[p+2], stream_q[p+1], stream_q[p]};
            x = x ^ stream_q[p] ^ stream_q[p+1] ^ stream_q[p+2] ^ stream_q[p+3];
            exp_addr.push_back(AW'(BASE) + AW'(k));
            exp_data.push_back(w);
            p += 4;
         end
         exp_cnt      = n;
         exp_consumed = p + 1;
         if (stream_q[p] == x) exp_done = 1'b1;
         else                  exp_err  = 1'b1;
      end
   endfunction

   // Build a random load of n words; corrupt flips the checksum.
   function automatic void build(input int unsigned n, input bit corrupt, input bit hdr_only);
      logic [31:0] nv;
      logic [7:0]  x;
      logic [7:0]  b;
      nv = n;
      stream_q.delete();
      stream_q.push_back(nv[7:0]);
      stream_q.push_back(nv[15:8]);
      stream_q.push_back(nv[23:16]);
      stream_q.push_back(nv[31:24]);
      if (!hdr_only) begin
         x = 8'd0;
         for (int i = 0; i < int'(n) * 4; i++) begin
            b = 8'($urandom);
            stream_q.push_back(b);
            x = x ^ b;
         end
         stream_q.push_back(corrupt ? (x ^ 8'($urandom_range(1, 255))) : x);
      end
   endfunction

   function automatic void set_good();
      stream_q = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h14, 8'h01, 8'h00, 8'h00,
                   8'h14, 8'h02, 8'h00, 8'h00, 8'h03};
   endfunction

   task automatic send_byte(input logic [7:0] b, input bit gappy);
      bit ok;
      if (gappy) begin
         repeat ($urandom_range(0, 2)) begin
            bvalid = 1'b0;
            bdata  = 8'($urandom);
            tick();
         end
      end
      bvalid = 1'b1;
      bdata  = b;
      ok = 1'b0;
      for (int t = 0; t < 64 && !ok; t++) begin
         tick();
         if (last_ready === 1'b1) ok = 1'b1;
      end
      bvalid = 1'b0;
      n_cmp++;
      if (!ok) begin
         n_fail++;
         $display("FAIL byte_accept: byte %h not accepted within 64 cycles, want accepted", b);
      end
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // Drive the current stream_q and compare the result against the model.
   task automatic run_load(input string name, input bit do_start, input bit gappy);
      int base_w;
      int base_d;
      int nw;
      base_w = cap_addr.size();
      base_d = done_cnt;
      run_model();
      if (do_start) pulse_start();
      for (int i = 0; i < exp_consumed; i++) send_byte(stream_q[i], gappy);
      repeat (4) tick();
      nw = cap_addr.size() - base_w;
      n_cmp++;
      if (nw != exp_addr.size()) begin
         n_fail++;
         $display("FAIL %s write_count: got %0d, want %0d", name, nw, exp_addr.size());
      end
      for (int i = 0; i < nw && i < exp_addr.size(); i++) begin
         n_cmp++;
         if (cap_addr[base_w+i] !== exp_addr[i] || cap_data[base_w+i] !== exp_data[i]) begin
            n_fail++;
            $display("FAIL %s write[%0d]: got %h=%h, want %h=%h", name, i,
                     cap_addr[base_w+i], cap_data[base_w+i], exp_addr[i], exp_data[i]);
         end
      end
      n_cmp++;
      if ((done_cnt - base_d) != (exp_done ? 1 : 0)) begin
         n_fail++;
         $display("FAIL %s done_pulses: got %0d, want %0d", name, done_cnt - base_d, exp_done ? 1 : 0);
      end
      n_cmp++;
      if (o_err !== exp_err || o_core_hold !== exp_err || o_byte_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL %s status: got err=%b hold=%b ready=%b, want err=%b hold=%b ready=0",
                  name, o_err, o_core_hold, o_byte_ready, exp_err, exp_err);
      end
      n_cmp++;
      if (o_words_written !== AW'(exp_cnt)) begin
         n_fail++;
         $display("FAIL %s words_written: got %0d, want %0d", name, o_words_written, exp_cnt);
      end
      if (exp_addr.size() > 0) begin
         n_cmp++;
         if (o_mem_waddr !== exp_addr[$] || o_mem_wdata !== exp_data[$]) begin
            n_fail++;
            $display("FAIL %s held_write: got %h=%h, want %h=%h", name,
                     o_mem_waddr, o_mem_wdata, exp_addr[$], exp_data[$]);
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; bvalid = 1'b1; bdata = 8'hA5;
      tick();
      tick();
      rst = 1'b0;
      bvalid = 1'b0;
      n_cmp++;
      if ({o_byte_ready, o_mem_wen, o_mem_wdata_valid, o_done, o_err, o_core_hold,
           o_mem_waddr, o_mem_wdata, o_words_written} !== '0) begin
         n_fail++;
         $display("FAIL reset_state: got rdy=%b wen=%b done=%b err=%b hold=%b addr=%h data=%h cnt=%0d, want all 0",
                  o_byte_ready, o_mem_wen, o_done, o_err, o_core_hold, o_mem_waddr, o_mem_wdata, o_words_written);
      end
   endtask

   task automatic test_good_load();
      int base_w;
      base_w = cap_addr.size();
      set_good();
      run_load("good", 1'b1, 1'b0);
      n_cmp++;
      if (cap_addr.size() < base_w + 2 || cap_data[base_w] !== 32'h0000_0114 ||
          cap_data[base_w+1] !== 32'h0000_0214 || cap_addr[base_w+1] !== 32'd1) begin
         n_fail++;
         $display("FAIL good_constants: got %0d writes, want 0=00000114 1=00000214", cap_addr.size() - base_w);
      end
   endtask

   task automatic test_bad_checksum();
      set_good();
      stream_q[12] = 8'h00;
      run_load("badchk", 1'b1, 1'b0);
      repeat (3) tick();
      n_cmp++;
      if (o_err !== 1'b1 || o_core_hold !== 1'b1) begin
         n_fail++;
         $display("FAIL badchk_sticky: got err=%b hold=%b, want 1 1", o_err, o_core_hold);
      end
      pulse_start();
      n_cmp++;
      if (o_err !== 1'b0 || o_words_written !== '0 || o_core_hold !== 1'b1 || o_byte_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL badchk_rearm: got err=%b cnt=%0d hold=%b rdy=%b, want 0 0 1 1",
                  o_err, o_words_written, o_core_hold, o_byte_ready);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic test_empty();
      stream_q = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      run_load("empty", 1'b1, 1'b0);
   endtask

   task automatic test_oversize();
      build(MAXW + 1, 1'b0, 1'b1);
      run_load("oversize", 1'b1, 1'b0);
      bvalid = 1'b1;
      bdata  = 8'h5A;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_cmp++;
         if (last_ready !== 1'b0 || o_err !== 1'b1) begin
            n_fail++;
            $display("FAIL oversize_err_idle: got rdy=%b err=%b, want 0 1", last_ready, o_err);
         end
      end
      bvalid = 1'b0;
      pulse_start();
      n_cmp++;
      if (o_err !== 1'b0 || o_byte_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL oversize_rearm: got err=%b rdy=%b, want 0 1", o_err, o_byte_ready);
      end
      stream_q = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      run_load("after_oversize", 1'b0, 1'b0);
   endtask

   task automatic test_max_words();
      build(MAXW, 1'b0, 1'b0);
      run_load("max_words", 1'b1, 1'b0);
   endtask

   task automatic test_reset_mid_load();
      int base_w;
      base_w = cap_addr.size();
      set_good();
      pulse_start();
      for (int i = 0; i < 10; i++) send_byte(stream_q[i], 1'b0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n_cmp++;
      if ({o_byte_ready, o_mem_wen, o_mem_wdata_valid, o_done, o_err, o_core_hold,
           o_mem_waddr, o_mem_wdata, o_words_written} !== '0) begin
         n_fail++;
         $display("FAIL midreset_state: got rdy=%b wen=%b hold=%b addr=%h data=%h cnt=%0d, want all 0",
                  o_byte_ready, o_mem_wen, o_core_hold, o_mem_waddr, o_mem_wdata, o_words_written);
      end
      repeat (4) tick();
      n_cmp++;
      if (cap_addr.size() != base_w + 1) begin
         n_fail++;
         $display("FAIL midreset_writes: got %0d, want 1", cap_addr.size() - base_w);
      end
      set_good();
      run_load("after_midreset", 1'b1, 1'b0);
   endtask

   task automatic test_gappy();
      bvalid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         bdata = 8'($urandom);
         tick();
         n_cmp++;
         if (last_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_ready: got %b, want 0", last_ready);
         end
      end
      bvalid = 1'b0;
      set_good();
      run_load("gappy", 1'b1, 1'b1);
   endtask

   task automatic test_random_loads();
      for (int r = 0; r < 6; r++) begin
         build($urandom_range(1, 6), ($urandom_range(0, 2) == 0), 1'b0);
         run_load("random", 1'b1, 1'b1);
      end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; bvalid = 1'b0; bdata = 8'h00; last_ready = 1'b0;
      test_reset();
      test_good_load();
      test_bad_checksum();
      test_empty();
      test_oversize();
      test_max_words();
      test_reset_mid_load();
      test_gappy();
      test_random_loads();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
